// File: rtl/reset_sequencer_if.sv
// Reset sequencer bus: per-stage ready inputs, reset outputs and status.
// master = sequencer side, slave = downstream subsystems side.
interface reset_sequencer_if #(
   parameter int STAGES = 3
);
   localparam int FSW = (STAGES > 1) ? $clog2(STAGES) : 1;

   logic [STAGES-1:0] stage_ready;
   logic [STAGES-1:0] stage_reset;
   logic              all_ready;
   logic              timeout;
   logic [FSW-1:0]    fault_stage;

   modport master (
      input  stage_ready,
      output stage_reset,
      output all_ready,
      output timeout,
      output fault_stage
   );

   modport slave (
      output stage_ready,
      input  stage_reset,
      input  all_ready,
      input  timeout,
      input  fault_stage
   );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset release: synchronize raw reset, then release each stage
// after a settle gap and wait for its ready before moving on.
module reset_sequencer #(
   parameter int STAGES         = 3,
   parameter int SYNC_STAGES    = 2,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   reset_sequencer_if.master bus
);
   localparam int FSW  = (STAGES > 1) ? $clog2(STAGES) : 1;
   localparam int MAXC = (GAP_CYCLES > TIMEOUT_CYCLES) ?
                         GAP_CYCLES : TIMEOUT_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [2:0] S_HOLD  = 3'd0;
   localparam logic [2:0] S_GAP   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_FAULT = 3'd4;

   localparam logic [CW-1:0]  GAP_LAST = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0]  TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [FSW-1:0] IDX_LAST = FSW'(STAGES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;

   logic [2:0]        state_q, state_d;
   logic [FSW-1:0]    idx_q,   idx_d;
   logic [CW-1:0]     cnt_q,   cnt_d;
   logic [STAGES-1:0] rst_q,   rst_d;
   logic              all_q,   all_d;
   logic              to_q,    to_d;
   logic [FSW-1:0]    fs_q,    fs_d;

   // Deassertion synchronizer: clears instantly, fills with ones on clk.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // Sequencing FSM next-state: hold, gap, wait for ready, done or fault.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      rst_d   = rst_q;
      all_d   = all_q;
      to_d    = to_q;
      fs_d    = fs_q;
      unique case (state_q)
         S_HOLD: begin
            if (synced) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               rst_d[idx_q] = 1'b0;
               state_d      = S_WAIT;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (bus.stage_ready[idx_q]) begin
               if (idx_q == IDX_LAST) begin
                  state_d = S_DONE;
                  all_d   = 1'b1;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_GAP;
                  cnt_d   = '0;
               end
            end else if (cnt_q == TO_LAST) begin
               state_d      = S_FAULT;
               to_d         = 1'b1;
               fs_d         = idx_q;
               rst_d[idx_q] = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  ;
         S_FAULT: ;
         default: ;
      endcase
   end

   // FSM and registered outputs; raw reset re-asserts everything at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_HOLD;
         idx_q   <= '0;
         cnt_q   <= '0;
         rst_q   <= '1;
         all_q   <= 1'b0;
         to_q    <= 1'b0;
         fs_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         rst_q   <= rst_d;
         all_q   <= all_d;
         to_q    <= to_d;
         fs_q    <= fs_d;
      end
   end

   assign bus.stage_reset = rst_q;
   assign bus.all_ready   = all_q;
   assign bus.timeout     = to_q;
   assign bus.fault_stage = fs_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: edge-timed reference model of the release
// schedule, directed scenarios plus randomized ready delays.
module tb_reset_sequencer;
   localparam int S    = 3;
   localparam int SYNC = 2;
   localparam int GAP  = 16;
   localparam int TO   = 1024;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   reset_sequencer_if #(.STAGES(S)) bus();

   reset_sequencer #(
      .STAGES(S),
      .SYNC_STAGES(SYNC),
      .GAP_CYCLES(GAP),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: dly[i] = edges after release until ready is seen (>TO = never).
   int dly[S];
   int rel[S];
   int ack[S];
   int f_edge;
   int f_idx;
   int done_edge;

   task automatic plan();
      int  e;
      bit  stop;
      e         = SYNC + 1;
      f_edge    = -1;
      f_idx     = 0;
      done_edge = -1;
      stop      = 1'b0;
      for (int i = 0; i < S; i++) begin
         rel[i] = -1;
         ack[i] = -1;
      end
      for (int i = 0; i < S; i++) begin
         if (!stop) begin
            rel[i] = e + GAP;
            if (dly[i] <= TO) begin
               ack[i] = rel[i] + dly[i];
               e      = ack[i];
            end else begin
               f_edge = rel[i] + TO;
               f_idx  = i;
               stop   = 1'b1;
            end
         end
      end
      if (f_edge < 0) done_edge = ack[S-1];
   endtask

   // Ready vector seen at edge m. mode 0: fixed; 1: random fill; 2: zero
   // fill. Modes 1/2 force each stage's wait window low and its ack high.
   function automatic logic [S-1:0] ready_for(int m, int mode,
                                              logic [S-1:0] fixed);
      logic [S-1:0] v;
      v = '0;
      for (int i = 0; i < S; i++) begin
         if (mode == 0) v[i] = fixed[i];
         else if (mode == 1) v[i] = 1'($urandom_range(0, 1));
         else v[i] = 1'b0;
         if (mode != 0 && rel[i] >= 0 && m > rel[i]) begin
            if (ack[i] < 0 || m < ack[i]) v[i] = 1'b0;
            else if (m == ack[i]) v[i] = 1'b1;
         end
      end
      return v;
   endfunction

   task automatic run_seq(int first, int last, int mode,
                          logic [S-1:0] fixed);
      logic [S-1:0]   er;
      logic           ea;
      logic           et;
      logic [1:0]     ef;
      bus.stage_ready = ready_for(first, mode, fixed);
      for (int n = first; n <= last; n++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < S; i++)
            er[i] = !(rel[i] >= 0 && n >= rel[i]);
         et = (f_edge >= 0 && n >= f_edge);
         if (et)
            for (int i = 0; i < S; i++)
               if (i >= f_idx) er[i] = 1'b1;
         ea = (done_edge >= 0 && n >= done_edge);
         ef = et ? 2'(f_idx) : 2'd0;
         checks++;
         if (bus.stage_reset !== er) begin
            errors++;
            $display("FAIL stage_reset edge %0d got %b want %b",
                     n, bus.stage_reset, er);
         end
         checks++;
         if (bus.all_ready !== ea) begin
            errors++;
            $display("FAIL all_ready edge %0d got %b want %b",
                     n, bus.all_ready, ea);
         end
         checks++;
         if (bus.timeout !== et) begin
            errors++;
            $display("FAIL timeout edge %0d got %b want %b",
                     n, bus.timeout, et);
         end
         checks++;
         if (bus.fault_stage !== ef) begin
            errors++;
            $display("FAIL fault_stage edge %0d got %0d want %0d",
                     n, bus.fault_stage, ef);
         end
         bus.stage_ready = ready_for(n + 1, mode, fixed);
      end
   endtask

   task automatic check_reset_vals(string tag);
      checks++;
      if (bus.stage_reset !== 3'b111) begin
         errors++;
         $display("FAIL %s stage_reset got %b want 111",
                  tag, bus.stage_reset);
      end
      checks++;
      if (bus.all_ready !== 1'b0 || bus.timeout !== 1'b0 ||
          bus.fault_stage !== 2'd0) begin
         errors++;
         $display("FAIL %s status got all=%b to=%b fs=%0d want 0 0 0",
                  tag, bus.all_ready, bus.timeout, bus.fault_stage);
      end
   endtask

   // Asynchronous drop mid-cycle, hold for some edges, release on negedge.
   task automatic drop_reset(int hold, string tag);
      #2 reset_n = 1'b0;
      #1 check_reset_vals(tag);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         #1 check_reset_vals(tag);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic set_nominal();
      for (int i = 0; i < S; i++) dly[i] = 1;
      plan();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.stage_ready = 3'b111;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1 check_reset_vals("por");
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_nominal();
      set_nominal();
      run_seq(1, 60, 0, 3'b111);
   endtask

   task automatic test_glitch();
      #2 reset_n = 1'b0;
      #1 check_reset_vals("glitch");
      #2 reset_n = 1'b1;
      set_nominal();
      run_seq(1, 60, 0, 3'b111);
   endtask

   task automatic test_post_done();
      run_seq(61, 110, 0, 3'b000);
   endtask

   task automatic test_mid_gap();
      drop_reset(0, "pre");
      set_nominal();
      run_seq(1, 25, 0, 3'b111);
      drop_reset(3, "midgap");
      run_seq(1, 60, 0, 3'b111);
   endtask

   task automatic test_stall();
      drop_reset(2, "pre_stall");
      dly[0] = 1;
      dly[1] = TO + 1;
      dly[2] = 1;
      plan();
      run_seq(1, 1260, 0, 3'b101);
   endtask

   task automatic test_boundary();
      drop_reset(2, "pre_bound");
      dly[0] = 1;
      dly[1] = TO;
      dly[2] = 1;
      plan();
      run_seq(1, 1090, 2, 3'b000);
   endtask

   task automatic test_random();
      int last;
      for (int it = 0; it < 8; it++) begin
         drop_reset(int'($urandom_range(1, 4)), "pre_rand");
         for (int i = 0; i < S; i++)
            dly[i] = int'($urandom_range(1, 50));
         if (it == 3) dly[$urandom_range(0, S-1)] = TO + 1;
         plan();
         last = (f_edge >= 0) ? f_edge + 30 : done_edge + 30;
         run_seq(1, last, 1, 3'b000);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_glitch();
      test_post_done();
      test_mid_gap();
      test_stall();
      test_boundary();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
